// File: rtl/battle_sequencer.sv
// Turn-level battle controller: sequences menu, player attack, act and enemy
// phases on a shared phase bus, with an enemy-phase watchdog and win/lose hold.
module battle_sequencer #(
  parameter int          NUM_TURNS     = 8,
  parameter logic [31:0] ACT_CYCLES    = 32'd37_125_000,
  parameter logic [31:0] ENEMY_TIMEOUT = 32'd742_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_in,
  input  logic       menu_done_in,
  input  logic [1:0] menu_choice_in,
  input  logic       attack_done_in,
  input  logic       enemy_busy_in,
  input  logic       enemy_finished_in,
  input  logic       enemy_hp_zero_in,
  input  logic       player_hp_zero_in,
  output logic [3:0] state_out,
  output logic [3:0] turn_out,
  output logic       phase_start_out,
  output logic       timeout_out,
  output logic       game_over_out,
  output logic       win_out
);

  typedef enum logic [3:0] {
    IDLE          = 4'b0000,
    MENU          = 4'b0001,
    PLAYER_ATTACK = 4'b0010,
    ACT           = 4'b0100,
    ENEMY         = 4'b1000,
    WIN           = 4'b1001,
    LOSE          = 4'b1010
  } state_t;

  localparam logic [3:0] LAST_TURN = 4'(NUM_TURNS - 1);

  state_t      state, state_nxt;
  logic [3:0]  turn, turn_nxt, turn_adv;
  logic [31:0] cnt, cnt_nxt;
  logic        timeout, timeout_nxt;
  logic        phase_start;

  // Enemy busy level is observed only; it never gates the phase exit.
  logic unused;
  assign unused = enemy_busy_in;

  assign turn_adv = (turn == LAST_TURN) ? 4'd0 : turn + 4'd1;

  always_comb begin
    state_nxt   = state;
    turn_nxt    = turn;
    timeout_nxt = timeout;
    case (state)
      IDLE, WIN, LOSE:
        if (start_in) begin
          state_nxt   = MENU;
          turn_nxt    = 4'd0;
          timeout_nxt = 1'b0;
        end
      MENU:
        if (menu_done_in)
          state_nxt = (menu_choice_in == 2'b00) ? PLAYER_ATTACK : ACT;
      PLAYER_ATTACK:
        if (attack_done_in)
          state_nxt = enemy_hp_zero_in ? WIN : ENEMY;
      ACT:
        if (cnt == ACT_CYCLES - 32'd1)
          state_nxt = ENEMY;
      ENEMY:
        // Player death wins over a clean finish, which wins over the watchdog.
        if (player_hp_zero_in) begin
          state_nxt = LOSE;
        end else if (enemy_finished_in) begin
          state_nxt = MENU;
          turn_nxt  = turn_adv;
        end else if (cnt == ENEMY_TIMEOUT - 32'd1) begin
          state_nxt   = MENU;
          turn_nxt    = turn_adv;
          timeout_nxt = 1'b1;
        end
      default: state_nxt = IDLE;
    endcase

    if (state_nxt != state)     cnt_nxt = 32'd0;
    else if (cnt == '1)         cnt_nxt = cnt;
    else                        cnt_nxt = cnt + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      turn        <= 4'd0;
      cnt         <= 32'd0;
      timeout     <= 1'b0;
      phase_start <= 1'b0;
    end else begin
      state       <= state_nxt;
      turn        <= turn_nxt;
      cnt         <= cnt_nxt;
      timeout     <= timeout_nxt;
      phase_start <= (state_nxt != state);
    end
  end

  assign state_out       = state;
  assign turn_out        = turn;
  assign phase_start_out = phase_start;
  assign timeout_out     = timeout;
  assign game_over_out   = (state == WIN) || (state == LOSE);
  assign win_out         = (state == WIN);

endmodule

// File: doc/battle_sequencer.md
# battle_sequencer

Turn-level controller for the battle screen. It sequences the player menu, the player attack, the act/item/mercy phase and the enemy attack phase. It drives the shared `state_out`/`turn_out` bus that the `enemy` block and the other phase blocks decode, waits on their completion handshakes, and guards the enemy phase with a watchdog. It also detects win/lose and holds the game-over screen until a new start.

## Interface
Parameters:
- `NUM_TURNS`, 8: number of enemy attack patterns; `turn_out` wraps modulo this value (1..16).
- `ACT_CYCLES`, 32'd37_125_000: fixed duration of the act/item/mercy phase in clocks (≥1).
- `ENEMY_TIMEOUT`, 32'd742_500_000: maximum clocks spent in the enemy phase before a forced exit (≥2).

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset, asynchronous, active-low.
- `start_in`, in, 1: one-cycle start/restart pulse.
- `menu_done_in`, in, 1: one-cycle pulse when the player confirms a menu choice.
- `menu_choice_in`, in, 2: menu choice, sampled with `menu_done_in`. 00 fight, 01 act, 10 item, 11 mercy.
- `attack_done_in`, in, 1: one-cycle pulse when the player attack animation completes.
- `enemy_busy_in`, in, 1: level from the enemy block.
- `enemy_finished_in`, in, 1: one-cycle pulse from the enemy block.
- `enemy_hp_zero_in`, in, 1: level; enemy HP is 0.
- `player_hp_zero_in`, in, 1: level; player HP is 0.
- `state_out`, out, 4: current phase code.
- `turn_out`, out, 4: current turn/pattern index.
- `phase_start_out`, out, 1: one-cycle pulse in the first cycle of every new phase.
- `timeout_out`, out, 1: sticky flag; an enemy phase was force-exited.
- `game_over_out`, out, 1: high in WIN or LOSE.
- `win_out`, out, 1: high in WIN only.

## Operation
Phase codes on `state_out`:
- IDLE 4'b0000
- MENU 4'b0001
- PLAYER_ATTACK 4'b0010
- ACT 4'b0100
- ENEMY 4'b1000
- WIN 4'b1001
- LOSE 4'b1010

Transitions (all registered):
- IDLE: on `start_in`, go to MENU with turn 0 and `timeout_out` cleared.
- MENU: on `menu_done_in`:
  - choice 00: go to PLAYER_ATTACK.
  - any other choice: go to ACT.
- PLAYER_ATTACK: on `attack_done_in`:
  - `enemy_hp_zero_in` = 1: go to WIN.
  - otherwise: go to ENEMY.
- ACT: a phase counter starts at 0 on entry. When it reaches ACT_CYCLES-1, go to ENEMY.
- ENEMY: a phase counter starts at 0 on entry.
  - `player_hp_zero_in` = 1 in any cycle: go to LOSE immediately, even mid-attack.
  - Else on `enemy_finished_in`: go to MENU and advance the turn.
  - Else when the counter reaches ENEMY_TIMEOUT-1: set `timeout_out`, go to MENU and advance the turn.
  - `enemy_busy_in` is monitored but does not gate exit.
- Turn advance: `turn_out` ← (`turn_out` == NUM_TURNS-1) ? 0 : `turn_out`+1.
- WIN/LOSE: hold. On `start_in`, go to MENU with turn 0 and `timeout_out` cleared.
- Inputs that are not relevant to the current phase are ignored; for example, `menu_done_in` during ENEMY has no effect.

Outputs and counter:
- `game_over_out` = (state == WIN || state == LOSE).
- `win_out` = (state == WIN).
- The phase counter is a single 32-bit register shared by ACT and ENEMY. It saturates and never wraps.

## Timing
- Reset (`rst` = 0, asynchronous) sets every output and register to 0: `state_out` = IDLE, `turn_out` = 0, `phase_start_out` = 0, `timeout_out` = 0, `game_over_out` = 0, `win_out` = 0, counter = 0.
- Reset mid-phase aborts the phase immediately. Release is synchronous to `clk`.
- Latency: an input sampled at edge N changes `state_out` after edge N, i.e. one cycle. `phase_start_out` is high in exactly that first cycle of the new phase.
- ACT occupies exactly ACT_CYCLES cycles of `state_out` = 4'b0100.
- ENEMY times out after exactly ENEMY_TIMEOUT cycles.
- Simultaneous events, in ENEMY:
  - `player_hp_zero_in` beats both `enemy_finished_in` and the timeout: go to LOSE, no turn advance, no timeout flag.
  - `enemy_finished_in` in the same cycle as the timeout: normal exit, `timeout_out` is not set.
- `start_in` during MENU, PLAYER_ATTACK, ACT or ENEMY is ignored.
- `turn_out` and `state_out` change in the same cycle when leaving ENEMY.

## Test plan
- Reset then fight path:
  - Stimulus: reset, `start_in`, `menu_done_in` with choice 00, `attack_done_in` with `enemy_hp_zero_in` = 0, `enemy_finished_in`.
  - Response: `state_out` goes 0000 → 0001 → 0010 → 1000 → 0001, `turn_out` = 1, and a `phase_start_out` pulse at each change.
- ACT duration (ACT_CYCLES = 5):
  - Stimulus: choice 10.
  - Response: `state_out` = 0100 for exactly 5 cycles, then 1000.
- Turn wrap (NUM_TURNS = 3):
  - Stimulus: 3 full rounds.
  - Response: `turn_out` goes 0 → 1 → 2 → 0.
- Watchdog (ENEMY_TIMEOUT = 10):
  - Stimulus: no `enemy_finished_in`.
  - Response: ENEMY lasts 10 cycles, then MENU, `timeout_out` = 1 and stays 1 until the next `start_in` from IDLE/WIN/LOSE.
  - Repeat with `enemy_finished_in` on the 10th ENEMY cycle: `timeout_out` stays 0.
- Win/lose and restart:
  - Stimulus: `attack_done_in` with `enemy_hp_zero_in` = 1.
  - Response: `state_out` = 1001, `win_out` = 1, `game_over_out` = 1.
  - Stimulus: `player_hp_zero_in` together with `enemy_finished_in` in ENEMY.
  - Response: `state_out` = 1010, `win_out` = 0, turn unchanged.
  - Stimulus: `start_in`.
  - Response: MENU, `turn_out` = 0.
- Async reset mid-ENEMY:
  - Stimulus: `rst` low between clock edges.
  - Response: all outputs are 0 before the next edge. After release, the block stays IDLE until `start_in`.
